// File: rtl/ezusb_fx3_pkg.sv
// rtl/ezusb_fx3_pkg.sv - shared widths, defaults and DMA0 entry type for the FX3 slave-FIFO emulator
package ezusb_fx3_pkg;
    localparam int WORD_W           = 16;
    localparam int PKT_BYTES        = 1024;
    localparam int PKT_WORDS_DEF    = PKT_BYTES / (WORD_W / 8);
    localparam int DEPTH_LOG2_DEF   = 10;
    localparam int FLAG_LAT_DEF     = 3;
    localparam int FULL_MARGIN_DEF  = 4;
    localparam int EMPTY_MARGIN_DEF = 2;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } dma0_word_t;

    localparam int DMA0_W = $bits(dma0_word_t);
endpackage

// File: rtl/ezusb_fx3_emu_if.sv
// rtl/ezusb_fx3_emu_if.sv - GPIF-II slave-FIFO pins plus host-side DMA streams
interface ezusb_fx3_emu_if;
    import ezusb_fx3_pkg::*;

    logic [WORD_W-1:0] fd_i;
    logic [WORD_W-1:0] fd_o;
    logic              fd_oe;
    logic              SLWR;
    logic              SLRD;
    logic              SLOE;
    logic              PKTEND;
    logic              EMPTY_FLAG;
    logic              FULL_FLAG;
    logic [WORD_W-1:0] h_out_data;
    logic              h_out_last;
    logic              h_out_valid;
    logic              h_out_ready;
    logic [WORD_W-1:0] h_in_data;
    logic              h_in_valid;
    logic              h_in_ready;
    logic [1:0]        err;

    modport slave (
        input  fd_i, SLWR, SLRD, SLOE, PKTEND, h_out_ready, h_in_data, h_in_valid,
        output fd_o, fd_oe, EMPTY_FLAG, FULL_FLAG, h_out_data, h_out_last, h_out_valid,
               h_in_ready, err
    );

    modport master (
        output fd_i, SLWR, SLRD, SLOE, PKTEND, h_out_ready, h_in_data, h_in_valid,
        input  fd_o, fd_oe, EMPTY_FLAG, FULL_FLAG, h_out_data, h_out_last, h_out_valid,
               h_in_ready, err
    );
endinterface

// File: rtl/ezusb_fx3_fifo.sv
// rtl/ezusb_fx3_fifo.sv - synchronous first-word-fall-through FIFO with level output
// mark sets the top bit of the most recently written entry (used to close short packets).
module ezusb_fx3_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  mark,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(1) << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [0:(1 << DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] last_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign do_wr    = wr_en && (level != FULL_LEVEL);
    assign do_rd    = rd_en && (level != '0);
    assign last_ptr = wr_ptr - DEPTH_LOG2'(1);
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end else if (mark) begin
            mem[last_ptr][WIDTH-1] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (do_rd) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({do_wr, do_rd})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/ezusb_fx3_emu.sv
// rtl/ezusb_fx3_emu.sv - FX3 side of the GPIF-II slave FIFO: DMA0 sink, DMA1 source, delayed flags
module ezusb_fx3_emu
    import ezusb_fx3_pkg::*;
#(
    parameter int DEPTH_LOG2   = DEPTH_LOG2_DEF,
    parameter int PKT_WORDS    = PKT_WORDS_DEF,
    parameter int FLAG_LAT     = FLAG_LAT_DEF,
    parameter int FULL_MARGIN  = FULL_MARGIN_DEF,
    parameter int EMPTY_MARGIN = EMPTY_MARGIN_DEF
) (
    input  logic              ifclk,
    input  logic              reset,
    ezusb_fx3_emu_if.slave    bus
);
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam int CNT_W = $clog2(PKT_WORDS + 1);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(1) << DEPTH_LOG2;

    logic [LVL_W-1:0]  level0;
    logic [LVL_W-1:0]  level1;
    logic [LVL_W-1:0]  free0;
    dma0_word_t        wr0_word;
    dma0_word_t        rd0_word;
    logic [DMA0_W-1:0] rd0_bits;
    logic              full0;
    logic              wr0;
    logic              mark0;
    logic              pop0;
    logic              push1;
    logic              pop1;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [WORD_W-1:0] rd1_data;
    logic [WORD_W-1:0] stage1;
    logic              ready_en;
    logic              raw_full;
    logic              raw_empty;
    logic [FLAG_LAT-1:0] full_sr;
    logic [FLAG_LAT-1:0] empty_sr;

    // A word written while PKTEND is low closes the packet itself; otherwise PKTEND retro-marks the last one.
    assign full0         = (level0 == FULL_LEVEL);
    assign wr0           = !bus.SLWR && !full0;
    assign wr0_word.data = bus.fd_i;
    assign wr0_word.last = !bus.PKTEND || (pkt_cnt == CNT_W'(PKT_WORDS - 1));
    assign mark0         = !bus.PKTEND && !wr0 && (pkt_cnt != '0);

    assign rd0_word        = dma0_word_t'(rd0_bits);
    assign bus.h_out_valid = (level0 != '0);
    assign bus.h_out_data  = rd0_word.data;
    assign bus.h_out_last  = bus.h_out_valid && rd0_word.last;
    assign pop0            = bus.h_out_valid && bus.h_out_ready;

    assign bus.h_in_ready = ready_en && (level1 != FULL_LEVEL);
    assign push1          = bus.h_in_valid && bus.h_in_ready;
    assign pop1           = !bus.SLRD;

    assign free0          = FULL_LEVEL - level0;
    assign raw_full       = (free0 <= LVL_W'(FULL_MARGIN));
    assign raw_empty      = (level1 <= LVL_W'(EMPTY_MARGIN));
    assign bus.FULL_FLAG  = full_sr[FLAG_LAT-1];
    assign bus.EMPTY_FLAG = empty_sr[FLAG_LAT-1];

    ezusb_fx3_fifo #(.WIDTH(DMA0_W), .DEPTH_LOG2(DEPTH_LOG2)) u_dma0 (
        .clk     (ifclk),
        .reset   (reset),
        .wr_en   (wr0),
        .wr_data (wr0_word),
        .mark    (mark0),
        .rd_en   (pop0),
        .rd_data (rd0_bits),
        .level   (level0)
    );

    ezusb_fx3_fifo #(.WIDTH(WORD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_dma1 (
        .clk     (ifclk),
        .reset   (reset),
        .wr_en   (push1),
        .wr_data (bus.h_in_data),
        .mark    (1'b0),
        .rd_en   (pop1),
        .rd_data (rd1_data),
        .level   (level1)
    );

    always_ff @(posedge ifclk) begin
        if (reset) begin
            pkt_cnt   <= '0;
            stage1    <= '0;
            bus.fd_o  <= '0;
            bus.fd_oe <= 1'b0;
            bus.err   <= 2'b00;
            ready_en  <= 1'b0;
            full_sr   <= '1;
            empty_sr  <= '0;
        end else begin
            ready_en <= 1'b1;

            if (wr0) begin
                pkt_cnt <= wr0_word.last ? '0 : pkt_cnt + CNT_W'(1);
            end else if (!bus.PKTEND) begin
                pkt_cnt <= '0;
            end
            if (!bus.SLWR && full0) bus.err[0] <= 1'b1;

            // Underrun still advances the read pipe, carrying zero instead of stale data.
            if (pop1) begin
                if (level1 == '0) begin
                    stage1     <= '0;
                    bus.err[1] <= 1'b1;
                end else begin
                    stage1 <= rd1_data;
                end
            end
            bus.fd_o  <= stage1;
            bus.fd_oe <= !bus.SLOE;

            full_sr[0]  <= !raw_full;
            empty_sr[0] <= !raw_empty;
            for (int i = 1; i < FLAG_LAT; i++) begin
                full_sr[i]  <= full_sr[i-1];
                empty_sr[i] <= empty_sr[i-1];
            end
        end
    end
endmodule

// File: tb/tb_ezusb_fx3_emu.sv
// tb/tb_ezusb_fx3_emu.sv - directed self-checking bench for ezusb_fx3_emu
module tb_ezusb_fx3_emu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;

    ezusb_fx3_emu_if bus ();

    ezusb_fx3_emu dut (
        .ifclk (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.fd_i        = '0;
        bus.SLWR        = 1'b1;
        bus.SLRD        = 1'b1;
        bus.SLOE        = 1'b1;
        bus.PKTEND      = 1'b1;
        bus.h_out_ready = 1'b0;
        bus.h_in_data   = '0;
        bus.h_in_valid  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (4) tick();
        n_assert++; if (bus.FULL_FLAG !== 1'b1) begin n_fail++; $display("FAIL reset_full_flag: got %b want 1", bus.FULL_FLAG); end
        n_assert++; if (bus.EMPTY_FLAG !== 1'b0) begin n_fail++; $display("FAIL reset_empty_flag: got %b want 0", bus.EMPTY_FLAG); end
        n_assert++; if (bus.fd_oe !== 1'b0) begin n_fail++; $display("FAIL reset_fd_oe: got %b want 0", bus.fd_oe); end
        n_assert++; if (bus.h_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_h_in_ready: got %b want 0", bus.h_in_ready); end
        n_assert++; if (bus.err !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", bus.err); end
        n_assert++; if (bus.h_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_h_out_valid: got %b want 0", bus.h_out_valid); end
        n_assert++; if (bus.fd_o !== 16'h0000) begin n_fail++; $display("FAIL reset_fd_o: got %h want 0000", bus.fd_o); end
        reset = 1'b0;
        tick();
        n_assert++; if (bus.h_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_h_in_ready: got %b want 1", bus.h_in_ready); end
    endtask

    task automatic test_full_packet;
        for (int i = 0; i < 512; i++) begin
            bus.SLWR = 1'b0;
            bus.fd_i = 16'(i);
            tick();
        end
        bus.SLWR = 1'b1;
        bus.h_out_ready = 1'b1;
        for (int i = 0; i < 512; i++) begin
            n_assert++;
            if (bus.h_out_valid !== 1'b1 || bus.h_out_data !== 16'(i) || bus.h_out_last !== (i == 511)) begin
                n_fail++;
                $display("FAIL pkt512_word[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         i, bus.h_out_valid, bus.h_out_data, bus.h_out_last, 16'(i), (i == 511));
            end
            tick();
        end
        bus.h_out_ready = 1'b0;
        n_assert++; if (bus.h_out_valid !== 1'b0) begin n_fail++; $display("FAIL pkt512_drained: got %b want 0", bus.h_out_valid); end
    endtask

    task automatic test_short_packet;
        logic [15:0] exp_d [5];
        logic        exp_l [5];
        exp_d = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00B1, 16'h00B2};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            bus.SLWR = 1'b0;
            bus.fd_i = exp_d[i];
            tick();
        end
        bus.SLWR = 1'b1;
        bus.PKTEND = 1'b0;
        tick();
        bus.PKTEND = 1'b1;
        bus.SLWR = 1'b0;
        bus.fd_i = 16'h00B1;
        tick();
        bus.fd_i = 16'h00B2;
        bus.PKTEND = 1'b0;
        tick();
        bus.SLWR = 1'b1;
        bus.PKTEND = 1'b1;
        bus.h_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_assert++;
            if (bus.h_out_valid !== 1'b1 || bus.h_out_data !== exp_d[i] || bus.h_out_last !== exp_l[i]) begin
                n_fail++;
                $display("FAIL short_pkt_word[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         i, bus.h_out_valid, bus.h_out_data, bus.h_out_last, exp_d[i], exp_l[i]);
            end
            tick();
        end
        bus.PKTEND = 1'b0;
        tick();
        bus.PKTEND = 1'b1;
        repeat (3) tick();
        bus.h_out_ready = 1'b0;
        n_assert++; if (bus.h_out_valid !== 1'b0) begin n_fail++; $display("FAIL zlp_no_output: got %b want 0", bus.h_out_valid); end
        n_assert++; if (bus.err !== 2'b00) begin n_fail++; $display("FAIL zlp_no_err: got %b want 00", bus.err); end
    endtask

    task automatic test_dma1_read;
        logic [15:0] exp;
        for (int i = 0; i < 8; i++) begin
            bus.h_in_valid = 1'b1;
            bus.h_in_data  = 16'h0010 + 16'(i);
            tick();
        end
        bus.h_in_valid = 1'b0;
        bus.SLOE = 1'b0;
        repeat (4) tick();
        n_assert++; if (bus.fd_oe !== 1'b1) begin n_fail++; $display("FAIL sloe_fd_oe: got %b want 1", bus.fd_oe); end
        n_assert++; if (bus.EMPTY_FLAG !== 1'b1) begin n_fail++; $display("FAIL dma1_not_empty: got %b want 1", bus.EMPTY_FLAG); end
        bus.SLRD = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (j >= 2) begin
                exp = (j >= 9) ? 16'h0017 : 16'h0010 + 16'(j - 2);
                n_assert++; if (bus.fd_o !== exp) begin n_fail++; $display("FAIL slrd_fd_o[%0d]: got %h want %h", j, bus.fd_o, exp); end
            end
            n_assert++;
            if (bus.EMPTY_FLAG !== (j <= 8)) begin
                n_fail++;
                $display("FAIL empty_flag_lat[%0d]: got %b want %b", j, bus.EMPTY_FLAG, (j <= 8));
            end
            if (j == 8) bus.SLRD = 1'b1;
        end
        n_assert++; if (bus.err !== 2'b00) begin n_fail++; $display("FAIL dma1_read_err: got %b want 00", bus.err); end
    endtask

    task automatic test_underrun;
        bus.SLRD = 1'b0;
        tick();
        bus.SLRD = 1'b1;
        n_assert++; if (bus.fd_o !== 16'h0017) begin n_fail++; $display("FAIL underrun_pipe_hold: got %h want 0017", bus.fd_o); end
        n_assert++; if (bus.err !== 2'b10) begin n_fail++; $display("FAIL underrun_err: got %b want 10", bus.err); end
        tick();
        n_assert++; if (bus.fd_o !== 16'h0000) begin n_fail++; $display("FAIL underrun_fd_o: got %h want 0000", bus.fd_o); end
        bus.SLOE = 1'b1;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        n_assert++; if (bus.err !== 2'b00) begin n_fail++; $display("FAIL underrun_err_cleared: got %b want 00", bus.err); end
    endtask

    task automatic test_overrun;
        for (int n = 1; n <= 1024; n++) begin
            bus.SLWR = 1'b0;
            bus.fd_i = 16'(n - 1);
            tick();
            if (n >= 1016) begin
                n_assert++;
                if (bus.FULL_FLAG !== (n < 1023)) begin
                    n_fail++;
                    $display("FAIL full_flag_lat[%0d]: got %b want %b", n, bus.FULL_FLAG, (n < 1023));
                end
            end
        end
        n_assert++; if (bus.err !== 2'b00) begin n_fail++; $display("FAIL fill_no_err: got %b want 00", bus.err); end
        bus.fd_i = 16'hDEAD;
        tick();
        bus.SLWR = 1'b1;
        n_assert++; if (bus.err !== 2'b01) begin n_fail++; $display("FAIL overrun_err: got %b want 01", bus.err); end
        bus.h_out_ready = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            n_assert++;
            if (bus.h_out_valid !== 1'b1 || bus.h_out_data !== 16'(i) || bus.h_out_last !== ((i % 512) == 511)) begin
                n_fail++;
                $display("FAIL overrun_data[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         i, bus.h_out_valid, bus.h_out_data, bus.h_out_last, 16'(i), ((i % 512) == 511));
            end
            tick();
        end
        bus.h_out_ready = 1'b0;
        n_assert++; if (bus.h_out_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_word_dropped: got %b want 0", bus.h_out_valid); end
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < 5; i++) begin
            bus.SLWR = 1'b0;
            bus.fd_i = 16'h0300 + 16'(i);
            bus.h_in_valid = (i < 3);
            bus.h_in_data  = 16'h0400 + 16'(i);
            tick();
        end
        bus.SLWR = 1'b1;
        bus.h_in_valid = 1'b0;
        bus.SLOE = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        n_assert++; if (bus.h_out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_h_out_valid: got %b want 0", bus.h_out_valid); end
        n_assert++; if (bus.h_in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_h_in_ready: got %b want 0", bus.h_in_ready); end
        n_assert++; if (bus.err !== 2'b00) begin n_fail++; $display("FAIL midreset_err: got %b want 00", bus.err); end
        n_assert++; if (bus.FULL_FLAG !== 1'b1) begin n_fail++; $display("FAIL midreset_full_flag: got %b want 1", bus.FULL_FLAG); end
        n_assert++; if (bus.EMPTY_FLAG !== 1'b0) begin n_fail++; $display("FAIL midreset_empty_flag: got %b want 0", bus.EMPTY_FLAG); end
        n_assert++; if (bus.fd_oe !== 1'b0) begin n_fail++; $display("FAIL midreset_fd_oe: got %b want 0", bus.fd_oe); end
        reset = 1'b0;
        bus.SLOE = 1'b1;
        repeat (4) tick();
        n_assert++; if (bus.h_out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_dma0_discarded: got %b want 0", bus.h_out_valid); end
        n_assert++; if (bus.EMPTY_FLAG !== 1'b0) begin n_fail++; $display("FAIL midreset_dma1_discarded: got %b want 0", bus.EMPTY_FLAG); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_full_packet();
        test_short_packet();
        test_dma1_read();
        test_underrun();
        test_overrun();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
